// File: rtl/data_source_pkg.sv
// Shared definitions for the data_source burst generator: widths, FSM states
// and the fixed 16-entry lookup table (entry i = (7*i + 3) mod 16).
package data_source_pkg;

  localparam int DEFAULT_ADDR_W = 4;
  localparam int DEFAULT_DATA_W = 4;
  localparam int ROM_DEPTH      = 16;
  localparam int ROM_W          = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Entry i lives at bits [i*ROM_W +: ROM_W]; entry 15 is the leftmost nibble.
  localparam logic [ROM_DEPTH*ROM_W-1:0] ROM_TABLE = {
    4'hC, 4'h5, 4'hE, 4'h7, 4'h0, 4'h9, 4'h2, 4'hB,
    4'h4, 4'hD, 4'h6, 4'hF, 4'h8, 4'h1, 4'hA, 4'h3
  };

endpackage

// File: rtl/data_source_rom.sv
// Combinational lookup into the package table; the caller registers the result.
module data_source_rom
  import data_source_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] words [DEPTH];

  // Entries beyond the fixed table read as zero if the address space is widened.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    if (gi < ROM_DEPTH) begin : g_used
      assign words[gi] = DATA_W'(ROM_TABLE[gi*ROM_W +: ROM_W]);
    end else begin : g_unused
      assign words[gi] = '0;
    end
  end

  assign data = words[addr];

endmodule

// File: rtl/data_source.sv
// Burst generator: on ena while idle, plays the whole table out as registered
// address/data pairs, one per clock, then returns to idle.
module data_source
  import data_source_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out
);

  // Declaration initialisers give the reset values at power-up as well.
  state_t            state_reg = IDLE;
  logic [ADDR_W-1:0] addr_reg  = '0;
  logic [DATA_W-1:0] data_reg  = '0;
  logic              valid_reg = 1'b0;

  logic [ADDR_W-1:0] rom_addr_next;
  logic [DATA_W-1:0] rom_data_next;

  // Look up the word for the address that will be presented after this edge.
  always_comb begin
    rom_addr_next = '0;
    if (state_reg == RUN) begin
      rom_addr_next = addr_reg + ADDR_W'(1);
    end
  end

  data_source_rom #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_rom (
    .addr(rom_addr_next),
    .data(rom_data_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (ena) begin
            state_reg <= RUN;
            addr_reg  <= '0;
            data_reg  <= rom_data_next;
            valid_reg <= 1'b1;
          end else begin
            addr_reg  <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
          end
        end
        RUN: begin
          // ena is deliberately ignored here: bursts are never retriggered.
          if (addr_reg == '1) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
          end else begin
            addr_reg  <= rom_addr_next;
            data_reg  <= rom_data_next;
            valid_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          addr_reg  <= '0;
          data_reg  <= '0;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign addr_out  = addr_reg;
  assign data_out  = data_reg;
  assign valid_out = valid_reg;

endmodule

// File: tb/tb_data_source.sv
// Self-checking bench for data_source: a cycle model pushes the expected
// outputs at each rising edge; they are popped and compared on the falling edge.
module tb_data_source;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ena = 1'b0;
  logic [3:0] addr_out;
  logic [3:0] data_out;
  logic       valid_out;

  int n_checks = 0;
  int n_fail   = 0;
  int valid_cnt = 0;

  typedef struct packed {
    logic [3:0] addr;
    logic [3:0] data;
    logic       valid;
  } exp_t;

  exp_t exp_q [$];

  data_source dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .addr_out (addr_out),
    .data_out (data_out),
    .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] rom_ref(input int i);
    return 4'((7 * i + 3) % 16);
  endfunction

  // Reference model, advanced on every rising edge from the sampled inputs.
  bit m_run  = 1'b0;
  int m_addr = 0;

  always @(posedge clk) begin
    exp_t e;
    e = '0;
    if (rst) begin
      m_run  = 1'b0;
      m_addr = 0;
    end else if (!m_run) begin
      if (ena) begin
        m_run  = 1'b1;
        m_addr = 0;
        e      = '{addr: 4'd0, data: rom_ref(0), valid: 1'b1};
      end
    end else if (m_addr == 15) begin
      m_run  = 1'b0;
      m_addr = 0;
    end else begin
      m_addr = m_addr + 1;
      e      = '{addr: 4'(m_addr), data: rom_ref(m_addr), valid: 1'b1};
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("addr_out", 32'(addr_out), 32'(e.addr));
      check("data_out", 32'(data_out), 32'(e.data));
      check("valid_out", 32'(valid_out), 32'(e.valid));
      $display("t=%0t addr=%h data=%h valid=%b", $time, addr_out, data_out, valid_out);
    end
    if (valid_out) valid_cnt++;
  end

  // Drive inputs well after the falling-edge check and before the next rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic wait_addr5();
    int k;
    for (k = 0; k < 40; k++) begin
      if (valid_out && addr_out == 4'd5) break;
      step(1);
    end
    if (k == 40) check("wait_addr5_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int c0;
    // Power-up state before any edge, with rst never asserted.
    #1;
    check("powerup_addr", 32'(addr_out), 32'd0);
    check("powerup_data", 32'(data_out), 32'd0);
    check("powerup_valid", 32'(valid_out), 32'd0);

    // Idle with ena low.
    step(10);

    // Three-cycle ena pulse gives exactly one burst.
    c0 = valid_cnt;
    ena = 1'b1;
    step(3);
    ena = 1'b0;
    step(30);
    check("pulse3_burst_len", 32'(valid_cnt - c0), 32'd16);

    // Continuous ena: back-to-back bursts with one idle gap.
    ena = 1'b1;
    step(40);
    ena = 1'b0;
    step(20);

    // Reset mid-burst at addr 5, then stay idle.
    ena = 1'b1;
    step(1);
    ena = 1'b0;
    wait_addr5();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(20);

    // Reset mid-burst at addr 5, then restart immediately.
    ena = 1'b1;
    step(1);
    ena = 1'b0;
    wait_addr5();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    ena = 1'b1;
    step(1);
    ena = 1'b0;
    step(20);

    // rst and ena together: rst wins, burst starts once rst drops.
    rst = 1'b1;
    ena = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    ena = 1'b0;
    step(20);

    // Single-cycle ena mid-burst is ignored.
    c0 = valid_cnt;
    ena = 1'b1;
    step(1);
    ena = 1'b0;
    step(8);
    ena = 1'b1;
    step(1);
    ena = 1'b0;
    step(30);
    check("midburst_ena_len", 32'(valid_cnt - c0), 32'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
